// File: rtl/cmp_sample_packer.sv
// Packs N_CH comparator bits per clock into WORD_W-bit words and streams them out
// over a valid/ready port, in continuous or fixed-length burst mode, with frame marks.
module cmp_sample_packer #(
   parameter int N_CH        = 4,
   parameter int WORD_W      = 80,
   parameter int MARK_PERIOD = 1024
) (
   input  logic              sample_clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   cmp_data,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic              en,
   input  logic              burst_mode,
   input  logic              start,
   input  logic [15:0]       burst_len,
   input  logic              clr_stat,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_mark,
   input  logic              m_ready,
   output logic              busy,
   output logic              overflow,
   output logic [15:0]       drop_cnt,
   output logic [1:0]        state_dbg
);

   localparam int S    = WORD_W / N_CH;
   localparam int SC_W = (S > 1) ? $clog2(S) : 1;
   localparam logic [SC_W-1:0] LAST_SAMP = SC_W'(S - 1);
   localparam logic [15:0]     MARK_P    = MARK_PERIOD[15:0];

   if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("cmp_sample_packer: N_CH must be 1..16");
   end
   if (WORD_W % N_CH != 0) begin : g_bad_width
      $error("cmp_sample_packer: WORD_W must be a multiple of N_CH");
   end
   if (MARK_PERIOD < 1 || MARK_PERIOD > 65535) begin : g_bad_mark
      $error("cmp_sample_packer: MARK_PERIOD must be 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [N_CH-1:0]   cmp_r;
   logic [WORD_W-1:0] acc, acc_nxt;
   logic [SC_W-1:0]   samp_cnt;
   logic [15:0]       word_idx;
   logic              burst_r;
   logic [15:0]       burst_len_r;
   logic              word_done, load, drop, last_word, mark_nxt;

   // Output handshake: a word transfers on any edge where m_valid and m_ready are
   // both 1; while m_valid=1 and m_ready=0, m_data/m_mark hold and new words drop.
   always_comb begin
      acc_nxt   = acc;
      acc_nxt[int'(samp_cnt)*N_CH +: N_CH] = cmp_r;
      word_done = (state == RUN) && (samp_cnt == LAST_SAMP);
      load      = word_done && (!m_valid || m_ready);
      drop      = word_done && m_valid && !m_ready;
      last_word = burst_r && ((word_idx + 16'd1) == burst_len_r);
      mark_nxt  = ((word_idx % MARK_P) == 16'd0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (burst_mode) begin
               if (start && (burst_len != 16'd0)) state_nxt = RUN;
            end else if (en) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (burst_r) begin
               if (word_done && last_word) state_nxt = DRAIN;
            end else if (!en) begin
               state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (!m_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sample_clk) begin
      if (reset) begin
         state       <= IDLE;
         cmp_r       <= '0;
         acc         <= '0;
         samp_cnt    <= '0;
         word_idx    <= '0;
         burst_r     <= 1'b0;
         burst_len_r <= '0;
         m_data      <= '0;
         m_valid     <= 1'b0;
         m_mark      <= 1'b0;
         overflow    <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         state <= state_nxt;
         cmp_r <= cmp_data & ch_mask;

         // Mode and burst length are captured only while idle.
         if (state == IDLE) begin
            burst_r     <= burst_mode;
            burst_len_r <= burst_len;
            samp_cnt    <= '0;
            word_idx    <= '0;
         end else if (state == RUN) begin
            acc <= acc_nxt;
            if (word_done || (state_nxt == IDLE)) samp_cnt <= '0;
            else                                  samp_cnt <= samp_cnt + 1'b1;
            if (word_done) word_idx <= word_idx + 16'd1;
         end

         if (load) begin
            m_data  <= acc_nxt;
            m_mark  <= mark_nxt;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         if (drop) begin
            overflow <= 1'b1;
            if (clr_stat)                  drop_cnt <= 16'd1;
            else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end else if (clr_stat) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   assign busy      = (state != IDLE) | m_valid;
   assign state_dbg = state;

endmodule
